// File: rtl/ones_compliment_accum.sv
// ones_compliment_accum: accumulates a packet of WIDTH-bit words as a ones'
// complement sum. Carries out of each beat's add are deferred into the next
// beat and folded back exactly once after the last beat.
// Optional build macro ONES_COMP_INVERT_EN: when defined, out_sum presents the
// inverted sum (checksum form); when undefined, out_sum is the plain sum.
//
// Handshake rules (both ports): a transfer happens on a rising clk edge where
// valid && ready are both high. A producer holding valid keeps its data
// stable until the transfer. in_ready depends only on the FSM state, never on
// in_valid, and out_valid depends only on the FSM state, never on out_ready.
module ones_compliment_accum #(
  parameter int WIDTH   = 16,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_sum,
  output logic [COUNT_W-1:0] out_count,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    S_ACC  = 2'd0,
    S_FOLD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic               carry_q, carry_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;

  // Full-width beat add; the top bit becomes the deferred carry.
  logic [WIDTH:0]     beat_sum;

  // Beat adder: acc + data + deferred carry, one bit wider than the word.
  always_comb begin
    beat_sum = {1'b0, acc_q} + {1'b0, in_data} + {{WIDTH{1'b0}}, carry_q};
  end

  // Next-state and handshake outputs for the ACC / FOLD / DONE sequence.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      S_ACC: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_d   = beat_sum[WIDTH-1:0];
          carry_d = beat_sum[WIDTH];
          // Beat counter sticks at all-ones rather than wrapping.
          cnt_d   = (cnt_q == {COUNT_W{1'b1}}) ? cnt_q : cnt_q + COUNT_W'(1);
          if (in_last) begin
            state_d = S_FOLD;
          end
        end
      end
      S_FOLD: begin
        // A single fold suffices: acc all-ones with a pending carry cannot
        // occur, so this add never produces a carry of its own.
        acc_d   = acc_q + WIDTH'(carry_q);
        carry_d = 1'b0;
        state_d = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          acc_d   = '0;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = S_ACC;
        end
      end
      default: begin
        state_d = S_ACC;
        acc_d   = '0;
        carry_d = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers; reset discards any partial or pending packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_ACC;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef ONES_COMP_INVERT_EN
  assign out_sum = ~acc_q;
`else
  assign out_sum = acc_q;
`endif
  assign out_count = cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ones_compliment_accum.sv
// Testbench for ones_compliment_accum (WIDTH=16, COUNT_W=8).
// Driver tasks issue packets; each completed packet pushes its expected
// {count, sum} into exp_q, and a negedge monitor pops and compares results.
module tb_ones_compliment_accum;

  localparam int W  = 16;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_sum;
  logic [CW-1:0] out_count;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;

  logic [CW+W-1:0] exp_q[$];
  logic [W-1:0]    pkt[$];

  bit ready_force = 1'b0;
  bit ready_val   = 1'b0;
  bit pending     = 1'b0;
  int lat         = 0;

  ones_compliment_accum #(.WIDTH(W), .COUNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Consumer backpressure: random unless a test pins it.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      out_ready = ready_force ? ready_val : ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- reference model ----------------
  // Ones' complement sum of a packet: the value congruent to the plain integer
  // total modulo 2^W-1, in 1..2^W-1, or zero only for an all-zero packet.
  function automatic logic [W-1:0] ref_sum(input longint total);
    longint m;
    logic [W-1:0] s;
    m = (longint'(1) << W) - 1;
    if (total == 0) s = '0;
    else            s = W'(((total - 1) % m) + 1);
`ifdef ONES_COMP_INVERT_EN
    s = ~s;
`endif
    return s;
  endfunction

  function automatic logic [CW-1:0] ref_count(input int n);
    int lim;
    lim = (1 << CW) - 1;
    return CW'((n > lim) ? lim : n);
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    pending = 1'b0;
    @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_count", out_count, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [W-1:0] d, input logic l);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      guard++;
      @(negedge clk);
    end
    if (!in_ready) check("beat_accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = W'($urandom);
    in_last  = 1'($urandom);
  endtask

  // Sends every word in pkt (last flagged on the final one) and records the
  // expected result once the final beat has been accepted.
  task automatic send_pkt(input bit bubbles);
    longint total;
    int n;
    total = 0;
    n = pkt.size();
    for (int i = 0; i < n; i++) begin
      if (bubbles) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send_beat(pkt[i], i == n - 1);
      total += longint'(pkt[i]);
    end
    exp_q.push_back({ref_count(n), ref_sum(total)});
    pending = 1'b1;
    lat     = 0;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0) && guard < 500) begin
      guard++;
      @(posedge clk);
      #1;
    end
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  function automatic logic [W-1:0] rand_word();
    case ($urandom_range(0, 4))
      0:       return '0;
      1:       return '1;
      2:       return W'(1) << (W - 1);
      default: return W'($urandom);
    endcase
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (pending) begin
        lat++;
        if (out_valid) begin
          check("latency_edges", lat, 2);
          pending = 1'b0;
        end
      end
      if (out_valid) begin
        check("in_ready_low_in_done", in_ready, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else if (out_ready) begin
          logic [CW+W-1:0] e;
          e = exp_q.pop_front();
          check("out_sum", out_sum, e[W-1:0]);
          check("out_count", out_count, e[CW+W-1:W]);
        end else begin
          check("held_out_sum", out_sum, exp_q[0][W-1:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Single all-ones beat: negative zero stays as is.
    ready_force = 1'b1; ready_val = 1'b1;
    pkt = '{16'hFFFF};
    send_pkt(1'b0);
    wait_drain();

    // Deferred carry folded back in.
    pkt = '{16'h8000, 16'h8000};
    send_pkt(1'b0);
    wait_drain();

    // Sum 0x0001 plain, 0xFFFE in checksum form.
    pkt = '{16'hFFFF, 16'h0001};
    send_pkt(1'b0);
    wait_drain();

    // Held result under backpressure; a waiting packet must not slip in.
    ready_val = 1'b0;
    pkt = '{16'h1234};
    send_pkt(1'b0);
    fork
      begin
        repeat (8) @(posedge clk);
        #1;
        ready_val = 1'b1;
      end
      begin
        pkt = '{16'h0001};
        send_pkt(1'b0);
      end
    join
    wait_drain();

    // Counter saturation with an all-zero packet.
    pkt.delete();
    for (int i = 0; i < 300; i++) pkt.push_back('0);
    send_pkt(1'b0);
    wait_drain();

    // Reset mid-packet: partial packet discarded.
    send_beat(16'h8000, 1'b0);
    send_beat(16'hFFFF, 1'b0);
    do_reset();
    pkt = '{16'h0002};
    send_pkt(1'b0);
    wait_drain();

    // Reset while a result is pending in DONE.
    ready_val = 1'b0;
    pkt = '{16'h4321, 16'h1111};
    send_pkt(1'b0);
    repeat (3) @(posedge clk);
    #1;
    do_reset();
    ready_val = 1'b1;
    pkt = '{16'h0003, 16'h0004};
    send_pkt(1'b0);
    wait_drain();

    // Randomized packets with bubbles and random backpressure.
    ready_force = 1'b0;
    for (int p = 0; p < 60; p++) begin
      int n;
      n = $urandom_range(1, 8);
      pkt.delete();
      for (int i = 0; i < n; i++) pkt.push_back(rand_word());
      send_pkt(1'b1);
    end
    wait_drain();

    // Back-to-back one-beat packets with the consumer always ready.
    ready_force = 1'b1; ready_val = 1'b1;
    for (int p = 0; p < 10; p++) begin
      pkt = '{W'($urandom)};
      send_pkt(1'b0);
    end
    wait_drain();

    repeat (4) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ones_compliment_accum.md
ONES_COMPLIMENT_ACCUM -- requirements
Module: ones_compliment_accum

Interface
REQ-001 Parameter WIDTH, default 16: word width of in_data and out_sum, legal range 4..64.
REQ-002 Parameter COUNT_W, default 8: width of the out_count beat counter, legal range 1..16.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  in_data/in_last valid this cycle.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 in_data  input  WIDTH  word to add (ones' complement).
REQ-008 in_last  input  1  marks final beat of a packet.
REQ-009 out_valid  output  1  out_sum/out_count valid.
REQ-010 out_ready  input  1  consumer takes the result this cycle.
REQ-011 out_sum  output  WIDTH  ones' complement sum of the packet.
REQ-012 out_count  output  COUNT_W  number of beats in the packet, saturating.

Function
REQ-013 Beat accepted on a rising edge where in_valid && in_ready; result handed off on a rising edge where out_valid && out_ready.
REQ-014 Internal state: acc (WIDTH bits), carry (1 bit), cnt (COUNT_W bits), FSM states ACC, FOLD, DONE.
REQ-015 ACC: in_ready=1, out_valid=0; each accepted beat sets {carry,acc} <= acc + in_data + carry (WIDTH+1-bit add, deferred end-around carry); cnt <= cnt+1, saturating at 2^COUNT_W-1.
REQ-016 ACC -> FOLD on an accepted beat with in_last=1; otherwise stay in ACC.
REQ-017 FOLD, exactly one cycle: in_ready=0, out_valid=0; acc <= acc + carry (WIDTH bits), carry <= 0; FOLD -> DONE unconditionally.
REQ-018 Carry-out of the FOLD add is always 0 (acc=all-ones with carry=1 is unreachable); no second fold exists.
REQ-019 DONE: in_ready=0, out_valid=1, out_sum and out_count driven from registers and held stable while out_ready=0.
REQ-020 DONE with out_ready=1: acc, carry, cnt cleared to 0; next state ACC; new packet beats accepted from the following cycle.
REQ-021 Latency: out_valid first high in the cycle after the FOLD cycle, i.e. two rising edges after the edge accepting the last beat.
REQ-022 Negative zero (all ones) is not normalised; out_sum=0x0...0 (without inversion) only when every input word was zero.
REQ-023 in_valid while in_ready=0 is ignored; the source holds the beat.
REQ-024 Throughput: one beat per cycle in ACC; three-cycle minimum packet turnaround for a one-beat packet with out_ready tied high.

Reset
REQ-025 rst=1 on a rising edge forces state ACC, acc=0, carry=0, cnt=0, out_valid=0, in_ready=1 on the next cycle; rst overrides every handshake.
REQ-026 rst asserted mid-packet, in FOLD, or in DONE discards the partial or pending result with no output handshake.

Configuration
REQ-027 Macro ONES_COMP_INVERT_EN defined: out_sum = ~acc (checksum form); out_count unaffected.
REQ-028 Macro ONES_COMP_INVERT_EN undefined: out_sum = acc (plain ones' complement sum).

Verification (WIDTH=16, COUNT_W=8, macro undefined unless stated)
REQ-029 One beat 0xFFFF, in_last=1 -> out_sum=0xFFFF, out_count=1, out_valid two edges after accept.
REQ-030 Beats 0x8000, 0x8000(last) -> carry deferred then folded; out_sum=0x0001, out_count=2.
REQ-031 Beats 0xFFFF, 0x0001(last) with ONES_COMP_INVERT_EN defined -> out_sum=0xFFFE, out_count=2.
REQ-032 Packet 0x1234(last) with out_ready=0 for 5 cycles -> out_sum=0x1234 held, in_ready=0 throughout; second packet 0x0001(last) accepted only after handoff -> out_sum=0x0001, out_count=1.
REQ-033 300 beats of 0x0000, last on beat 300 -> out_sum=0x0000, out_count=255 (saturated).
REQ-034 Beats 0x8000, 0xFFFF, then rst=1 for one cycle, then 0x0002(last) -> out_sum=0x0002, out_count=1, no output from the aborted packet.
